// File: rtl/spi_mstr_pkg.sv
// Shared types and reset defaults for the parametrised SPI master.
package spi_mstr_pkg;

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam logic      CPOL_RST = 1'b1;
  localparam logic      CPHA_RST = 1'b0;
  localparam spi_mode_t MODE_RST = '{cpol: CPOL_RST, cpha: CPHA_RST};

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: half-period strobe, leading/trailing edge strobes and SCLK level.
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  input  logic tog,
  input  logic cpol,
  output logic half,
  output logic lead,
  output logic trail,
  output logic sclk
);

  localparam int unsigned H = 2 ** (DIV_W - 1);

  logic [DIV_W-1:0] cnt;
  logic             phase;

  assign half  = run && (cnt == '0);
  assign lead  = half && tog && !phase;
  assign trail = half && tog && phase;
  assign sclk  = cpol ^ phase;

  // The load value is one above the reload value, giving the single extra
  // clock in the opening idle half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load) begin
      cnt   <= DIV_W'(H);
      phase <= 1'b0;
    end else if (run) begin
      cnt <= (cnt == '0) ? DIV_W'(H - 1) : cnt - DIV_W'(1);
      if (half && tog) phase <= ~phase;
    end
  end

endmodule

// File: rtl/spi_mstr_param.sv
// Parametrised SPI master: configurable width/rate, runtime CPOL/CPHA, decoded selects.
// Optional SPI_MSTR_LSB_FIRST_EN adds a latched lsb_first input.
module spi_mstr_param
  import spi_mstr_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned DIV_W  = 6,
  parameter  int unsigned NUM_SS = 1,
  localparam int unsigned SSW    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [SSW-1:0]    ss_sel,
`ifdef SPI_MSTR_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned CW = $clog2(DATA_W) + 1;

  spi_state_t        state, state_nxt;
  spi_mode_t         mode;
  logic [DATA_W-1:0] shreg, shreg_in;
  logic [CW-1:0]     bit_cnt;
  logic [NUM_SS-1:0] ss_dec;
  logic              miso_cap, lsb;
  logic              accept, tog, finish;
  logic              half, lead, trail;
  logic              capture, shift_en;

`ifdef SPI_MSTR_LSB_FIRST_EN
  logic lsb_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lsb_q <= 1'b0;
    else if (accept) lsb_q <= lsb_first;
  end
  assign lsb = lsb_q;
`else
  assign lsb = 1'b0;
`endif

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .run   (busy),
    .tog   (tog),
    .cpol  (mode.cpol),
    .half  (half),
    .lead  (lead),
    .trail (trail),
    .sclk  (SCLK)
  );

  assign busy = (state != IDLE);
  assign MOSI = lsb ? shreg[0] : shreg[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The last SHIFT half-period starts at the final trailing edge, so a full
  // bit count at a half strobe ends the shift phase without another toggle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tog       = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (wrt) begin
          accept    = 1'b1;
          state_nxt = FRONT;
        end
      end
      FRONT: begin
        if (half) begin
          tog       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (half) begin
          if (bit_cnt == CW'(DATA_W)) state_nxt = BACK;
          else                        tog       = 1'b1;
        end
      end
      BACK: begin
        if (half) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ss_dec = '1;
    for (int unsigned i = 0; i < NUM_SS; i++)
      if (ss_sel == SSW'(i)) ss_dec[i] = 1'b0;
  end

  assign capture  = mode.cpha ? trail : lead;
  assign shift_en = mode.cpha ? (lead && (state != FRONT)) : trail;
  assign shreg_in = lsb ? {miso_cap, shreg[DATA_W-1:1]} : {shreg[DATA_W-2:0], miso_cap};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode     <= MODE_RST;
      shreg    <= '0;
      bit_cnt  <= '0;
      miso_cap <= 1'b0;
      SS_n     <= '1;
      done     <= 1'b0;
      rd_data  <= '0;
    end else if (accept) begin
      mode    <= '{cpol, cpha};
      shreg   <= cmd;
      bit_cnt <= '0;
      SS_n    <= ss_dec;
      done    <= 1'b0;
    end else begin
      if (capture)  miso_cap <= MISO;
      if (shift_en) shreg    <= shreg_in;
      if (trail)    bit_cnt  <= bit_cnt + CW'(1);
      if (finish) begin
        SS_n    <= '1;
        done    <= 1'b1;
        rd_data <= mode.cpha ? shreg_in : shreg;
        if (mode.cpha) shreg <= shreg_in;
      end
    end
  end

endmodule
